divider_period_meter: RTL and testbench

- Receiving end of the even clock divider: samples a divided clock in the fast clock domain and measures its period in fast-clock cycles, recovering the divide factor N.
- Reports each measured period, a lock indication once the period is stable, and a stall indication when the divided clock stops.
- Sits beside divider instances as a self-check and bring-up monitor.

---
 rtl/divider_meter_pkg.sv | 17 +
 rtl/sync_rise_det.sv | 36 +++
 rtl/divider_period_meter.sv | 151 +++++++++++++++
 tb/tb_divider_period_meter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_meter_pkg.sv
// Shared types and constants for the divided-clock period meter.
// Latency: n/a (package); backpressure: n/a.
// Holds the FSM state encoding and the synchronizer depth.
package divider_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE,
        TRACK
    } state_t;

    localparam int SYNC_STAGES  = 2;
    // div_in rising edge to the clk edge that consumes the rise pulse
    localparam int RISE_LATENCY = 3;

endpackage

// File: rtl/sync_rise_det.sv
// Purpose: two-flop synchronizer for div_in plus an edge register producing a one-cycle rise pulse.
// Latency: the rise pulse is consumed on the third clk edge after div_in rises.
// Backpressure: none, free-running sampler.
module sync_rise_det
    import divider_meter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
`ifdef DIVIDER_DUTY_CHECK_EN
    ,
    output logic level
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef DIVIDER_DUTY_CHECK_EN
    assign level = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/divider_period_meter.sv
// Purpose: measures the period of a divided clock in clk cycles, with lock and stall flags (duty check under DIVIDER_DUTY_CHECK_EN).
// Latency: period/period_valid/locked update on the clk edge that consumes the rise pulse (3 clk after div_in rises).
// Backpressure: none; period_valid is a one-cycle pulse that is not held.
module divider_period_meter
    import divider_meter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LOCK_COUNT = 4,
    parameter int MAX_PERIOD = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             div_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled
`ifdef DIVIDER_DUTY_CHECK_EN
    ,
    output logic             duty_err
`endif
);

    localparam int             MW    = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]  LC    = MW'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_PERIOD);

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt;
    logic [MW-1:0]    match, match_next;
    logic             rise, at_max;
    logic             do_sample, do_load, do_stall;

`ifdef DIVIDER_DUTY_CHECK_EN
    logic             level;
    logic [WIDTH-1:0] hi_cnt;
`endif

    sync_rise_det u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (div_in),
        .rise    (rise)
`ifdef DIVIDER_DUTY_CHECK_EN
        ,
        .level   (level)
`endif
    );

    assign at_max = (cnt == MAX_P);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A rise pulse always takes precedence over the stall threshold.
    always_comb begin
        state_next = state;
        do_sample  = 1'b0;
        do_load    = 1'b0;
        do_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (rise) begin
                    state_next = MEASURE;
                    do_load    = 1'b1;
                end else if (at_max) begin
                    do_stall   = 1'b1;
                end
            end
            MEASURE, TRACK: begin
                if (rise) begin
                    state_next = TRACK;
                    do_sample  = 1'b1;
                end else if (at_max) begin
                    state_next = WAIT_EDGE;
                    do_stall   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    always_comb begin
        match_next = match;
        if (state == MEASURE || cnt != period) match_next = MW'(1);
        else if (match != LC)                  match_next = match + MW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            match        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else if (!enable) begin
            cnt          <= '0;
            match        <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            period_valid <= do_sample;
            if (do_sample) begin
                period <= cnt;
                cnt    <= WIDTH'(1);
                match  <= match_next;
                locked <= (match_next == LC);
            end else if (do_load) begin
                cnt     <= WIDTH'(1);
                stalled <= 1'b0;
            end else if (do_stall) begin
                cnt     <= '0;
                match   <= '0;
                locked  <= 1'b0;
                stalled <= 1'b1;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DIVIDER_DUTY_CHECK_EN
    // The rise cycle itself is the first high cycle of the new period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt   <= '0;
            duty_err <= 1'b0;
        end else if (!enable) begin
            hi_cnt   <= '0;
            duty_err <= 1'b0;
        end else begin
            if (do_sample) duty_err <= ({hi_cnt, 1'b0} != {1'b0, cnt});
            else if (do_stall) duty_err <= 1'b0;
            if (do_sample || do_load)
                hi_cnt <= WIDTH'(1);
            else if ((state == MEASURE || state == TRACK) && level)
                hi_cnt <= hi_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_divider_period_meter.sv
// Randomized and directed stimulus for divider_period_meter against a rise-time based reference model.
// Expected periods are queued when the stimulus drives a rise; a negedge monitor pops them on period_valid.
module tb_divider_period_meter;
    import divider_meter_pkg::*;

    localparam int WIDTH = 16;
    localparam int LOCK  = 4;
    localparam int MAXP  = 64;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable  = 1'b0;
    logic             div_in  = 1'b0;
    logic [WIDTH-1:0] period;
    logic             period_valid, locked, stalled;
`ifdef DIVIDER_DUTY_CHECK_EN
    logic             duty_err;
`endif

    divider_period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK), .MAX_PERIOD(MAXP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .div_in       (div_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .stalled      (stalled)
`ifdef DIVIDER_DUTY_CHECK_EN
        ,
        .duty_err     (duty_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int per;
        bit lk;
        bit duty;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   last_rise = -1;
    int   prev_high = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Locked when the most recent LOCK periods since the last restart are all equal.
    function automatic bit lock_of();
        if (hist.size() < LOCK) return 1'b0;
        for (int i = 1; i <= LOCK; i++)
            if (hist[hist.size()-i] != hist[hist.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void on_rise(input int now, input int h);
        exp_t e;
        if (last_rise >= 0 && (now - last_rise) <= MAXP) begin
            e.per  = now - last_rise;
            hist.push_back(e.per);
            e.lk   = lock_of();
            e.duty = (2 * prev_high != e.per);
            sb.push_back(e);
        end else begin
            hist.delete();
        end
        last_rise = now;
        prev_high = h;
    endfunction

    function automatic void model_restart();
        last_rise = -1;
        hist.delete();
    endfunction

    task automatic drive(input logic v, input int h);
        @(posedge clk);
        #1;
        if (v && !div_in) on_rise(cyc, h);
        div_in = v;
    endtask

    task automatic hold(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic run_wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) drive(1'b1, h);
            repeat (l) drive(1'b0, h);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (reset_n && period_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: period %0d with no expected entry (cycle %0d)", period, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("period", 64'(period), 64'(mon_e.per));
                check("locked", 64'(locked), 64'(mon_e.lk));
                check("stalled_at_valid", 64'(stalled), 64'd0);
`ifdef DIVIDER_DUTY_CHECK_EN
                check("duty_err", 64'(duty_err), 64'(mon_e.duty));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #2 reset_n = 1'b0;
        #2;
        check("reset_period", 64'(period), 64'd0);
        check("reset_valid", 64'(period_valid), 64'd0);
        check("reset_locked", 64'(locked), 64'd0);
        check("reset_stalled", 64'(stalled), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // No edges while waiting for the first one: stall from WAIT_EDGE.
        enable = 1'b1;
        hold(MAXP + 8);
        @(negedge clk);
        check("wait_edge_stall", 64'(stalled), 64'd1);
        check("wait_edge_locked", 64'(locked), 64'd0);

        // Period 4 lock, then switch to period 6 and relock.
        run_wave(2, 2, 6);
        run_wave(3, 3, 6);

        // Stall while locked at period 4.
        run_wave(2, 2, 6);
        @(negedge clk);
        check("locked_before_stall", 64'(locked), 64'd1);
        k = last_rise;
        while (cyc < k + 2 + MAXP) drive(1'b0, 0);
        @(negedge clk);
        check("stall_one_early", 64'(stalled), 64'd0);
        drive(1'b0, 0);
        @(negedge clk);
        check("stall_at_max", 64'(stalled), 64'd1);
        check("stall_unlocks", 64'(locked), 64'd0);
        check("stall_keeps_period", 64'(period), 64'd4);
`ifdef DIVIDER_DUTY_CHECK_EN
        check("stall_duty_clear", 64'(duty_err), 64'd0);
`endif
        drive(1'b1, 2);
        drive(1'b1, 2);
        drive(1'b0, 2);
        @(negedge clk);
        check("stall_held_pre_rise", 64'(stalled), 64'd1);
        drive(1'b0, 2);
        @(negedge clk);
        check("stall_cleared_on_rise", 64'(stalled), 64'd0);
        run_wave(2, 2, 5);

        // Exactly MAX_PERIOD is measured; one more cycle stalls.
        run_wave(32, 32, 3);
        run_wave(33, 32, 2);
        run_wave(2, 2, 3);

        // Drop enable mid-period at period 8.
        run_wave(4, 4, 6);
        repeat (4) drive(1'b1, 4);
        drive(1'b0, 4);
        enable = 1'b0;
        hold(12);
        @(negedge clk);
        check("disable_locked", 64'(locked), 64'd0);
        check("disable_stalled", 64'(stalled), 64'd0);
        check("disable_keeps_period", 64'(period), 64'd8);
        check("disable_no_pending", 64'(sb.size()), 64'd0);
        model_restart();
        enable = 1'b1;
        hold(3);
        run_wave(4, 4, 3);

`ifdef DIVIDER_DUTY_CHECK_EN
        run_wave(3, 5, 4);
        run_wave(4, 4, 5);
`endif

        // Randomized segments, occasionally with long low gaps around MAX_PERIOD.
        for (int s = 0; s < 30; s++) begin
            run_wave(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            if ($urandom_range(0, 5) == 0) hold(int'($urandom_range(50, 66)));
        end

        // Asynchronous reset while locked.
        run_wave(2, 2, 6);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_period", 64'(period), 64'd0);
        check("async_rst_valid", 64'(period_valid), 64'd0);
        check("async_rst_locked", 64'(locked), 64'd0);
        check("async_rst_stalled", 64'(stalled), 64'd0);
`ifdef DIVIDER_DUTY_CHECK_EN
        check("async_rst_duty", 64'(duty_err), 64'd0);
`endif
        check("async_rst_no_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        model_restart();
        @(negedge clk) reset_n = 1'b1;
        hold(2);
        run_wave(3, 2, 6);

        hold(10);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
